// File: rtl/prog_launcher_if.sv
// prog_launcher_if: handshake between the test-sequencing launcher and the
// fetch unit's Reset/Start hold port.
//   CoreStart  launcher -> fetch unit  1 = hold the PC at InitPC
//   InitPC     launcher -> fetch unit  entry address, valid while CoreStart = 1
//   CoreDone   fetch/core -> launcher  completion flag of the running program
// Modports: master = launcher side, slave = fetch unit / core side.
interface prog_launcher_if #(
  parameter int unsigned T = 10
);
  logic         CoreStart;
  logic [T-1:0] InitPC;
  logic         CoreDone;

  modport master (output CoreStart, output InitPC, input CoreDone);
  modport slave  (input CoreStart, input InitPC, output CoreDone);
endinterface

// File: rtl/prog_launcher.sv
// prog_launcher: holds the core's PC while a program is set up, presents its
// entry address, releases the core, then measures the run length until
// CoreDone. Steps through NPROG (1..3) programs and then reports SeqDone.
//
// Ports:
//   Clk, Reset       clock; synchronous active-high reset
//   i_Go             start/restart request (IDLE or FINISH only)
//   core_if          master side of the hold/start handshake
//   o_ProgIdx        current or last program index
//   o_Busy           high in LOAD and RUN
//   o_CycleCount     RUN cycles completed for the current program (saturating)
//   o_LastCount      run length of the most recently finished program
//   o_LastValid      one-cycle pulse when o_LastCount updates
//   o_SeqDone        high in FINISH
//   o_TimeoutErr     sticky timeout flag
//
// Optional feature, macro PROG_LAUNCH_TIMEOUT_EN: a program whose CycleCount
// reaches TIMEOUT in RUN is treated as finished and sets o_TimeoutErr. The
// TIMEOUT parameter only exists in that build; otherwise RUN waits forever
// and o_TimeoutErr is tied low.
//
// state  | meaning
// IDLE   | after reset, core held, waiting for Go
// LOAD   | core held at BASE[ProgIdx] for START_CYC cycles
// RUN    | core released, counting cycles until CoreDone
// FINISH | sequence complete, core held, waiting for Go to rerun
module prog_launcher #(
  parameter int unsigned T         = 10,
  parameter int unsigned C         = 16,
  parameter int unsigned NPROG     = 3,
  parameter int unsigned BASE0     = 0,
  parameter int unsigned BASE1     = 'h100,
  parameter int unsigned BASE2     = 'h200,
  parameter int unsigned START_CYC = 2
`ifdef PROG_LAUNCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 'hFFF0
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            i_Go,
  prog_launcher_if.master core_if,
  output logic [1:0]      o_ProgIdx,
  output logic            o_Busy,
  output logic [C-1:0]    o_CycleCount,
  output logic [C-1:0]    o_LastCount,
  output logic            o_LastValid,
  output logic            o_SeqDone,
  output logic            o_TimeoutErr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int unsigned LW = $clog2(START_CYC + 1);

  logic [1:0]    r_state;
  logic [LW-1:0] r_ld_cnt;
  logic          r_core_start;
  logic [T-1:0]  r_init_pc;
  logic [1:0]    r_prog_idx;
  logic          r_busy;
  logic [C-1:0]  r_cycle;
  logic [C-1:0]  r_last_count;
  logic          r_last_valid;
  logic          r_seq_done;

  logic [C-1:0]  w_cnt_inc;
  logic          w_last;
  logic          w_timeout;
  logic          w_complete;

  // Entry addresses are truncated to the PC width.
  function automatic logic [T-1:0] base_of(input logic [1:0] idx);
    case (idx)
      2'd1:    base_of = T'(BASE1);
      2'd2:    base_of = T'(BASE2);
      default: base_of = T'(BASE0);
    endcase
  endfunction

  // Saturating increment: the run length never wraps.
  assign w_cnt_inc = (r_cycle == '1) ? r_cycle : r_cycle + 1'b1;
  assign w_last    = (r_prog_idx == 2'(NPROG - 1));

`ifdef PROG_LAUNCH_TIMEOUT_EN
  logic r_timeout_err;

  // A same-edge CoreDone wins, so the flag is only raised for a real timeout.
  assign w_timeout    = !core_if.CoreDone && (w_cnt_inc == C'(TIMEOUT));
  assign o_TimeoutErr = r_timeout_err;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_timeout_err <= 1'b0;
    end else if (((r_state == S_IDLE) || (r_state == S_FINISH)) && i_Go) begin
      r_timeout_err <= 1'b0;
    end else if ((r_state == S_RUN) && w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout    = 1'b0;
  assign o_TimeoutErr = 1'b0;
`endif

  assign w_complete = core_if.CoreDone || w_timeout;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_ld_cnt     <= '0;
      r_core_start <= 1'b1;
      r_init_pc    <= T'(BASE0);
      r_prog_idx   <= 2'd0;
      r_busy       <= 1'b0;
      r_cycle      <= '0;
      r_last_count <= '0;
      r_last_valid <= 1'b0;
      r_seq_done   <= 1'b0;
    end else begin
      r_last_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (i_Go) begin
            r_state    <= S_LOAD;
            r_ld_cnt   <= LW'(START_CYC);
            r_prog_idx <= 2'd0;
            r_init_pc  <= T'(BASE0);
            r_cycle    <= '0;
            r_busy     <= 1'b1;
            r_seq_done <= 1'b0;
          end
        end
        S_LOAD: begin
          r_ld_cnt <= r_ld_cnt - 1'b1;
          // Leaving on the edge that takes the counter to zero keeps LOAD
          // exactly START_CYC cycles long.
          if (r_ld_cnt == LW'(1)) begin
            r_state      <= S_RUN;
            r_core_start <= 1'b0;
          end
        end
        S_RUN: begin
          r_cycle <= w_cnt_inc;
          if (w_complete) begin
            r_last_count <= w_cnt_inc;
            r_last_valid <= 1'b1;
            r_core_start <= 1'b1;
            if (w_last) begin
              r_state    <= S_FINISH;
              r_busy     <= 1'b0;
              r_seq_done <= 1'b1;
            end else begin
              r_state    <= S_LOAD;
              r_ld_cnt   <= LW'(START_CYC);
              r_prog_idx <= r_prog_idx + 2'd1;
              r_init_pc  <= base_of(r_prog_idx + 2'd1);
              r_cycle    <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_if.CoreStart = r_core_start;
  assign core_if.InitPC    = r_init_pc;
  assign o_ProgIdx         = r_prog_idx;
  assign o_Busy            = r_busy;
  assign o_CycleCount      = r_cycle;
  assign o_LastCount       = r_last_count;
  assign o_LastValid       = r_last_valid;
  assign o_SeqDone         = r_seq_done;

endmodule

// File: tb/tb_prog_launcher.sv
module tb_prog_launcher;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // DUT A: default three-program sequence
  logic        Reset_a, Go_a;
  logic [1:0]  pidx_a;
  logic        busy_a, lv_a, sd_a, te_a;
  logic [15:0] cc_a, lc_a;
  prog_launcher_if #(.T(10)) if_a ();

  prog_launcher #(
`ifdef PROG_LAUNCH_TIMEOUT_EN
    .TIMEOUT(20)
`endif
  ) dut_a (
    .Clk(Clk), .Reset(Reset_a), .i_Go(Go_a), .core_if(if_a.master),
    .o_ProgIdx(pidx_a), .o_Busy(busy_a), .o_CycleCount(cc_a),
    .o_LastCount(lc_a), .o_LastValid(lv_a), .o_SeqDone(sd_a),
    .o_TimeoutErr(te_a)
  );

  // DUT B: single program, minimum load time, BASE0 wider than the PC
  logic        Reset_b, Go_b;
  logic [1:0]  pidx_b;
  logic        busy_b, lv_b, sd_b, te_b;
  logic [15:0] cc_b, lc_b;
  prog_launcher_if #(.T(10)) if_b ();

  prog_launcher #(.NPROG(1), .START_CYC(1), .BASE0('h43C)) dut_b (
    .Clk(Clk), .Reset(Reset_b), .i_Go(Go_b), .core_if(if_b.master),
    .o_ProgIdx(pidx_b), .o_Busy(busy_b), .o_CycleCount(cc_b),
    .o_LastCount(lc_b), .o_LastValid(lv_b), .o_SeqDone(sd_b),
    .o_TimeoutErr(te_b)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered just after the edge that put DUT A into LOAD.
  task automatic run_prog(input logic [9:0] base, input logic [1:0] idx,
                          input int n, input bit last);
    chk("load_start", 32'(if_a.CoreStart), 1);
    chk("load_pc", 32'(if_a.InitPC), 32'(base));
    chk("load_idx", 32'(pidx_a), 32'(idx));
    chk("load_busy", 32'(busy_a), 1);
    tick();
    chk("load2_start", 32'(if_a.CoreStart), 1);
    chk("lv_one_cycle", 32'(lv_a), 0);
    tick();
    chk("run_start", 32'(if_a.CoreStart), 0);
    chk("run_cc0", 32'(cc_a), 0);
    for (int i = 1; i < n; i++) tick();
    chk("run_ccn", 32'(cc_a), 32'(n - 1));
    chk("run_no_lv", 32'(lv_a), 0);
    if_a.CoreDone = 1'b1;
    tick();
    if_a.CoreDone = 1'b0;
    chk("done_lc", 32'(lc_a), 32'(n));
    chk("done_lv", 32'(lv_a), 1);
    chk("done_start", 32'(if_a.CoreStart), 1);
    chk("done_seq", 32'(sd_a), 32'(last));
  endtask

  initial begin
    Reset_a = 1'b1; Go_a = 1'b0; if_a.CoreDone = 1'b0;
    Reset_b = 1'b1; Go_b = 1'b0; if_b.CoreDone = 1'b0;
    tick(); tick();

    // 1: reset state, idle stability
    chk("rst_start", 32'(if_a.CoreStart), 1);
    chk("rst_pc", 32'(if_a.InitPC), 0);
    chk("rst_seq", 32'(sd_a), 0);
    chk("rst_te", 32'(te_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_lc", 32'(lc_a), 0);
    Reset_a = 1'b0; Reset_b = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_start", 32'(if_a.CoreStart), 1);
    chk("idle_pc", 32'(if_a.InitPC), 0);
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_idx", 32'(pidx_a), 0);
    chk("idle_seq", 32'(sd_a), 0);

    // 2: full sequence 5, 7, 3
    Go_a = 1'b1; tick(); Go_a = 1'b0;
    run_prog(10'h000, 2'd0, 5, 1'b0);
    run_prog(10'h100, 2'd1, 7, 1'b0);
    run_prog(10'h200, 2'd2, 3, 1'b1);
    chk("fin_busy", 32'(busy_a), 0);
    tick();
    chk("fin_lv_pulse", 32'(lv_a), 0);
    chk("fin_seq_hold", 32'(sd_a), 1);
    chk("fin_idx_hold", 32'(pidx_a), 2);
    chk("fin_lc_hold", 32'(lc_a), 3);

    // 3: CoreDone held high across LOAD
    if_a.CoreDone = 1'b1;
    Go_a = 1'b1; tick(); Go_a = 1'b0;
    chk("restart_idx", 32'(pidx_a), 0);
    chk("restart_seq", 32'(sd_a), 0);
    chk("restart_pc", 32'(if_a.InitPC), 0);
    tick(); tick();
    chk("held_done_run", 32'(if_a.CoreStart), 0);
    chk("held_done_nolv", 32'(lv_a), 0);
    tick();
    if_a.CoreDone = 1'b0;
    chk("held_done_lc", 32'(lc_a), 1);
    chk("held_done_lv", 32'(lv_a), 1);

    // 4: reset on the 4th RUN cycle of program 1
    chk("p1_pc", 32'(if_a.InitPC), 'h100);
    chk("p1_idx", 32'(pidx_a), 1);
    tick(); tick();
    chk("p1_run", 32'(if_a.CoreStart), 0);
    tick(); tick(); tick();
    chk("p1_cc3", 32'(cc_a), 3);
    Reset_a = 1'b1; if_a.CoreDone = 1'b1;
    tick();
    Reset_a = 1'b0; if_a.CoreDone = 1'b0;
    chk("mid_rst_lv", 32'(lv_a), 0);
    chk("mid_rst_lc", 32'(lc_a), 0);
    chk("mid_rst_start", 32'(if_a.CoreStart), 1);
    chk("mid_rst_pc", 32'(if_a.InitPC), 0);
    chk("mid_rst_idx", 32'(pidx_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_cc", 32'(cc_a), 0);
    tick();
    chk("post_rst_idle", 32'(busy_a), 0);
    Go_a = 1'b1; tick(); Go_a = 1'b0;
    run_prog(10'h000, 2'd0, 2, 1'b0);
    run_prog(10'h100, 2'd1, 1, 1'b0);
    run_prog(10'h200, 2'd2, 4, 1'b1);
    tick();

`ifdef PROG_LAUNCH_TIMEOUT_EN
    // 5: core never done, TIMEOUT = 20
    Go_a = 1'b1; tick(); Go_a = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick(); tick();
      chk("to_run", 32'(if_a.CoreStart), 0);
      for (int i = 0; i < 19; i++) tick();
      chk("to_cc19", 32'(cc_a), 19);
      chk("to_nolv", 32'(lv_a), 0);
      tick();
      chk("to_lc", 32'(lc_a), 20);
      chk("to_lv", 32'(lv_a), 1);
      chk("to_err", 32'(te_a), 1);
      chk("to_seq", 32'(sd_a), (p == 2) ? 1 : 0);
    end
    tick();
    chk("to_err_sticky", 32'(te_a), 1);
    Go_a = 1'b1; tick(); Go_a = 1'b0;
    chk("to_err_clear", 32'(te_a), 0);
    chk("to_restart_busy", 32'(busy_a), 1);
`endif

    // 6: NPROG = 1, Go ignored during RUN, rerun from FINISH
    Go_b = 1'b1; tick(); Go_b = 1'b0;
    chk("b_load_pc", 32'(if_b.InitPC), 'h03C);
    chk("b_load_start", 32'(if_b.CoreStart), 1);
    tick();
    chk("b_run", 32'(if_b.CoreStart), 0);
    Go_b = 1'b1; tick(); Go_b = 1'b0;
    chk("b_go_ign_run", 32'(if_b.CoreStart), 0);
    chk("b_go_ign_cc", 32'(cc_b), 1);
    chk("b_go_ign_busy", 32'(busy_b), 1);
    tick();
    if_b.CoreDone = 1'b1; tick(); if_b.CoreDone = 1'b0;
    chk("b_done_lc", 32'(lc_b), 3);
    chk("b_done_seq", 32'(sd_b), 1);
    chk("b_done_idx", 32'(pidx_b), 0);
    chk("b_done_busy", 32'(busy_b), 0);
    tick();
    Go_b = 1'b1; tick(); Go_b = 1'b0;
    chk("b_rerun_pc", 32'(if_b.InitPC), 'h03C);
    chk("b_rerun_busy", 32'(busy_b), 1);
    chk("b_rerun_seq", 32'(sd_b), 0);
    tick();
    chk("b_rerun_run", 32'(if_b.CoreStart), 0);
    chk("b_te", 32'(te_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
